// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receive path.
// Imported by ps2_clk_filter and ps2_kbd_rx.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PFX_REL = 8'hF0;

    typedef struct packed {
        logic       ext;
        logic       rel;
        logic [7:0] code;
    } kbd_evt_t;

    // PS/2 frames carry odd parity over the data byte plus the parity bit.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// PS/2 pin conditioning: two-flop synchronisers on both pins, a FILTER_LEN-sample
// glitch filter on the clock and a one-cycle strike on each filtered falling edge.
module ps2_clk_filter
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_ps2_clk,
    input  logic i_ps2_data,
    output logic o_strike,
    output logic o_data
);

    logic                  r_clk_meta;
    logic                  r_clk_sync;
    logic                  r_dat_meta;
    logic                  r_dat_sync;
    logic [FILTER_LEN-1:0] r_shift;
    logic                  r_filt;
    logic                  r_strike;

    logic w_all_low;
    logic w_all_high;

    assign w_all_low  = (r_shift == '0);
    assign w_all_high = &r_shift;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_clk_meta <= 1'b1;
            r_clk_sync <= 1'b1;
            r_dat_meta <= 1'b1;
            r_dat_sync <= 1'b1;
        end else begin
            r_clk_meta <= i_ps2_clk;
            r_clk_sync <= r_clk_meta;
            r_dat_meta <= i_ps2_data;
            r_dat_sync <= r_dat_meta;
        end
    end

    // Filtered clock only moves once the whole window agrees on the new level.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_shift  <= '1;
            r_filt   <= 1'b1;
            r_strike <= 1'b0;
        end else begin
            r_shift  <= {r_shift[FILTER_LEN-2:0], r_clk_sync};
            r_strike <= r_filt & w_all_low;
            if (w_all_low) begin
                r_filt <= 1'b0;
            end else if (w_all_high) begin
                r_filt <= 1'b1;
            end
        end
    end

    assign o_strike = r_strike;
    assign o_data   = r_dat_sync;

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: frame deserialiser, E0/F0 prefix folding and event FIFO.
// Optional frame watchdog enabled by defining PS2_RX_TIMEOUT_EN.
module ps2_kbd_rx
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN  = 4,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned TIMEOUT_CYC = 28000
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       ps2_kbd_clk,
    input  logic       ps2_kbd_data,
    output logic       key_valid,
    input  logic       key_ready,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_release,
    output logic       err_frame,
    output logic       err_parity,
    output logic       overflow
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

    logic w_strike;
    logic w_data;

    ps2_clk_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_filter (
        .i_clk      (clk_sys),
        .i_rst_n    (reset),
        .i_ps2_clk  (ps2_kbd_clk),
        .i_ps2_data (ps2_kbd_data),
        .o_strike   (w_strike),
        .o_data     (w_data)
    );

    rx_state_t  r_state;
    logic [2:0] r_bit_cnt;
    logic [7:0] r_byte;
    logic       r_par;
    logic       r_ext_pend;
    logic       r_rel_pend;
    logic       r_err_frame;
    logic       r_err_parity;
    logic       r_overflow;

    kbd_evt_t   r_mem [FIFO_DEPTH];
    logic [PTR_W:0] r_wr_ptr;
    logic [PTR_W:0] r_rd_ptr;

    logic     w_timeout;
    logic     w_frame_done;
    logic     w_par_ok;
    logic     w_is_pfx;
    logic     w_push;
    logic     w_pop;
    logic     w_wr_en;
    logic     w_empty;
    logic     w_full;
    kbd_evt_t w_evt;
    kbd_evt_t w_head;

`ifdef PS2_RX_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TO_W-1:0] r_to_cnt;

    assign w_timeout = (r_to_cnt == TO_W'(TIMEOUT_CYC));

    always_ff @(posedge clk_sys or negedge reset) begin
        if (!reset) begin
            r_to_cnt <= '0;
        end else if (w_strike || w_timeout) begin
            r_to_cnt <= '0;
        end else if (r_state != IDLE) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    assign w_frame_done = w_strike && (r_state == STOP);
    assign w_par_ok     = odd_parity_ok(r_byte, r_par);
    assign w_is_pfx     = (r_byte == PS2_PFX_EXT) || (r_byte == PS2_PFX_REL);
    assign w_push       = w_frame_done && !w_timeout && w_data && w_par_ok && !w_is_pfx;

    always_comb begin
        w_evt      = '0;
        w_evt.ext  = r_ext_pend;
        w_evt.rel  = r_rel_pend;
        w_evt.code = r_byte;
    end

    always_ff @(posedge clk_sys or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_bit_cnt    <= 3'd0;
            r_byte       <= 8'h00;
            r_par        <= 1'b0;
            r_ext_pend   <= 1'b0;
            r_rel_pend   <= 1'b0;
            r_err_frame  <= 1'b0;
            r_err_parity <= 1'b0;
        end else begin
            r_err_frame  <= 1'b0;
            r_err_parity <= 1'b0;
            if (w_timeout) begin
                r_state     <= IDLE;
                r_err_frame <= 1'b1;
                r_ext_pend  <= 1'b0;
                r_rel_pend  <= 1'b0;
            end else if (w_strike) begin
                unique case (r_state)
                    IDLE: begin
                        if (!w_data) begin
                            r_state   <= DATA;
                            r_bit_cnt <= 3'd0;
                        end
                    end
                    DATA: begin
                        r_byte    <= {w_data, r_byte[7:1]};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            r_state <= PARITY;
                        end
                    end
                    PARITY: begin
                        r_par   <= w_data;
                        r_state <= STOP;
                    end
                    STOP: begin
                        r_state <= IDLE;
                        if (!w_data) begin
                            r_err_frame <= 1'b1;
                            r_ext_pend  <= 1'b0;
                            r_rel_pend  <= 1'b0;
                        end else if (!w_par_ok) begin
                            r_err_parity <= 1'b1;
                            r_ext_pend   <= 1'b0;
                            r_rel_pend   <= 1'b0;
                        end else if (r_byte == PS2_PFX_EXT) begin
                            r_ext_pend <= 1'b1;
                        end else if (r_byte == PS2_PFX_REL) begin
                            r_rel_pend <= 1'b1;
                        end else begin
                            // Pend flags clear even if the FIFO drops the event.
                            r_ext_pend <= 1'b0;
                            r_rel_pend <= 1'b0;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                     (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
    assign w_pop   = !w_empty && key_ready;
    assign w_wr_en = w_push && (!w_full || w_pop);

    always_ff @(posedge clk_sys or negedge reset) begin
        if (!reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= w_push && w_full && !w_pop;
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr[PTR_W-1:0]] <= w_evt;
        end
    end

    // Head fields read as zero while the FIFO is empty, including out of reset.
    assign w_head      = w_empty ? '0 : r_mem[r_rd_ptr[PTR_W-1:0]];
    assign key_valid   = !w_empty;
    assign key_code    = w_head.code;
    assign key_ext     = w_head.ext;
    assign key_release = w_head.rel;
    assign err_frame   = r_err_frame;
    assign err_parity  = r_err_parity;
    assign overflow    = r_overflow;

endmodule
